// File: rtl/sumu3_exerciser.sv
// Sweeps all sixteen 2-bit operand pairs through an external sum/mult/abs-diff unit
// and tallies vectors whose returned results disagree with the expected arithmetic.
module sumu3_exerciser #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] a,
  output logic [1:0] b,
  input  logic [2:0] sum,
  input  logic [2:0] mult,
  input  logic [2:0] abb,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] cnt_q;
  logic [1:0] a_q;
  logic [1:0] b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_q;
  logic [3:0] ff_q;

  logic [1:0] ea;
  logic [1:0] eb;
  logic [2:0] exp_sum;
  logic [2:0] exp_mult;
  logic [2:0] exp_abb;
  logic       vec_bad;
  logic [4:0] err_d;
  logic [3:0] idx_d;

  // Expected results for the current vector and the resulting error count.
  always_comb begin
    ea       = idx_q[3:2];
    eb       = idx_q[1:0];
    exp_sum  = {1'b0, ea} + {1'b0, eb};
    exp_mult = {1'b0, ea} * {1'b0, eb};
    if (ea >= eb) begin
      exp_abb = {1'b0, ea - eb};
    end else begin
      exp_abb = {1'b0, eb - ea};
    end
    vec_bad = (sum != exp_sum) || (mult != exp_mult) || (abb != exp_abb);
    // Sixteen vectors can never exceed 16, but the count must not wrap regardless.
    if (vec_bad && (err_q != 5'd16)) begin
      err_d = err_q + 5'd1;
    end else begin
      err_d = err_q;
    end
    idx_d = idx_q + 4'd1;
  end

  // Sweep sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      a_q     <= 2'd0;
      b_q     <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      ff_q    <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_q    <= 2'd0;
          b_q    <= 2'd0;
          done_q <= 1'b0;
          if (start) begin
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
            ff_q    <= 4'd0;
            idx_q   <= 4'd0;
            cnt_q   <= SETTLE_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (vec_bad && (err_q == 5'd0)) begin
            ff_q <= idx_q;
          end
          if (idx_q == 4'd15) begin
            a_q     <= 2'd0;
            b_q     <= 2'd0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 5'd0);
            state_q <= S_FINISH;
          end else begin
            idx_q   <= idx_d;
            a_q     <= idx_d[3:2];
            b_q     <= idx_d[1:0];
            cnt_q   <= SETTLE_LOAD;
            state_q <= S_SETTLE;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_sumu3_exerciser.sv
// Bench for sumu3_exerciser: models the unit under test with injectable faults and
// predicts sweep results from the arithmetic rules directly.
module tb_sumu3_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start3;
  logic [1:0] a1, b1, a3, b3;
  logic [2:0] sum1, mult1, abb1, sum3, mult3, abb3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [4:0] err1, err3;
  logic [3:0] ff1, ff3;

  // Fault mode of the modelled unit: 0 ok, 1 mult stuck 0, 2 abb stuck 0, 3 sum stuck 0.
  int         mode;
  logic [2:0] c_sum [16];
  logic [2:0] c_mult[16];
  logic [2:0] c_abb [16];

  int total = 0;
  int bad   = 0;

  function automatic logic [2:0] uut(input int field, input int md, input logic [2:0] cs,
                                     input logic [1:0] x, input logic [1:0] y);
    int ix, iy, r;
    ix = int'(x);
    iy = int'(y);
    case (field)
      0:       r = (md == 3) ? 0 : ix + iy;
      1:       r = (md == 1) ? 0 : (ix * iy) % 8;
      default: r = (md == 2) ? 0 : ((ix > iy) ? ix - iy : iy - ix);
    endcase
    return 3'(r) ^ cs;
  endfunction

  assign sum1  = uut(0, mode, c_sum [{a1, b1}], a1, b1);
  assign mult1 = uut(1, mode, c_mult[{a1, b1}], a1, b1);
  assign abb1  = uut(2, mode, c_abb [{a1, b1}], a1, b1);
  assign sum3  = uut(0, mode, c_sum [{a3, b3}], a3, b3);
  assign mult3 = uut(1, mode, c_mult[{a3, b3}], a3, b3);
  assign abb3  = uut(2, mode, c_abb [{a3, b3}], a3, b3);

  sumu3_exerciser #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .sum(sum1), .mult(mult1), .abb(abb1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .first_fail(ff1)
  );

  sumu3_exerciser #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .sum(sum3), .mult(mult3), .abb(abb3), .busy(busy3), .done(done3),
    .pass(pass3), .err_cnt(err3), .first_fail(ff3)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else          start1 = v;
  endtask

  task automatic clear_masks();
    for (int k = 0; k < 16; k++) begin
      c_sum[k]  = 3'd0;
      c_mult[k] = 3'd0;
      c_abb[k]  = 3'd0;
    end
  endtask

  // Launch a sweep and follow it to done, checking the a/b order on every cycle.
  task automatic run_sweep(input int sel, input int pulse_at, input bit hold,
                           output int lat, output int busy_n, output int ab_bad,
                           output int pulsed);
    int s, exp_lat, k, vi;
    logic [1:0] aa, bb;
    logic dn, bz;
    s       = (sel != 0) ? 3 : 1;
    exp_lat = 16 * (s + 1) + 1;
    lat = 0; busy_n = 0; ab_bad = 0; pulsed = 0;
    set_start(sel, 1'b1);
    do begin
      tick();
      lat++;
      aa = (sel != 0) ? a3 : a1;
      bb = (sel != 0) ? b3 : b1;
      bz = (sel != 0) ? busy3 : busy1;
      dn = (sel != 0) ? done3 : done1;
      vi = int'(aa) * 4 + int'(bb);
      if (pulse_at >= 0 && pulsed == 0 && vi == pulse_at) begin
        set_start(sel, 1'b1);
        pulsed = 1;
      end else if (!hold) begin
        set_start(sel, 1'b0);
      end
      if (bz) busy_n++;
      if (lat < exp_lat) begin
        k = (lat - 1) / (s + 1);
        if (int'(aa) != k / 4 || int'(bb) != k % 4) ab_bad++;
      end else if (aa != 2'd0 || bb != 2'd0) begin
        ab_bad++;
      end
    end while (!dn && lat < 400);
  endtask

  typedef struct {
    string name;
    int    md;
    int    exp_err;
    int    exp_ff;
    int    exp_pass;
  } vec_t;

  vec_t tbl[4];
  int lat, busy_n, ab_bad, pulsed, ee, ef, guard;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{"correct",   0, 0,  -1, 1};
    tbl[1] = '{"mult_zero", 1, 9,  5,  0};
    tbl[2] = '{"abb_zero",  2, 12, 1,  0};
    tbl[3] = '{"sum_zero",  3, 15, 1,  0};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 0;
    clear_masks();
    repeat (3) tick();
    chk("rst_ab",   int'({a1, b1}), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err",  int'(err1), 0);
    chk("rst_ff",   int'(ff1), 0);
    rst_n = 1'b1;
    tick();

    // Fixed fault table on the SETTLE=1 instance.
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].md;
      run_sweep(0, -1, 1'b0, lat, busy_n, ab_bad, pulsed);
      chk({tbl[i].name, "_latency"}, lat, 33);
      chk({tbl[i].name, "_busy_cycles"}, busy_n, 33);
      chk({tbl[i].name, "_ab_order"}, ab_bad, 0);
      chk({tbl[i].name, "_err"}, int'(err1), tbl[i].exp_err);
      chk({tbl[i].name, "_pass"}, int'(pass1), tbl[i].exp_pass);
      if (tbl[i].exp_ff >= 0) chk({tbl[i].name, "_first_fail"}, int'(ff1), tbl[i].exp_ff);
      tick();
      chk({tbl[i].name, "_done_one_cycle"}, int'(done1), 0);
      chk({tbl[i].name, "_idle_busy"}, int'(busy1), 0);
      repeat (3) tick();
      chk({tbl[i].name, "_hold_err"}, int'(err1), tbl[i].exp_err);
      chk({tbl[i].name, "_hold_pass"}, int'(pass1), tbl[i].exp_pass);
    end

    // Random per-vector corruption against a counting model.
    mode = 0;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 16; k++) begin
        if (r == 6) begin
          c_sum[k] = 3'd7; c_mult[k] = 3'd0; c_abb[k] = 3'd0;
        end else begin
          c_sum[k]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
          c_mult[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
          c_abb[k]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end
      end
      ee = 0; ef = 0;
      for (int k = 0; k < 16; k++) begin
        if ((c_sum[k] | c_mult[k] | c_abb[k]) != 3'd0) begin
          if (ee == 0) ef = k;
          ee++;
        end
      end
      run_sweep(0, -1, 1'b0, lat, busy_n, ab_bad, pulsed);
      chk("rand_latency", lat, 33);
      chk("rand_err", int'(err1), ee);
      chk("rand_pass", int'(pass1), (ee == 0) ? 1 : 0);
      if (ee != 0) chk("rand_first_fail", int'(ff1), ef);
      tick();
    end
    clear_masks();

    // SETTLE=3 instance: longer sweep, a/b held four cycles per vector.
    run_sweep(1, -1, 1'b0, lat, busy_n, ab_bad, pulsed);
    chk("s3_latency", lat, 65);
    chk("s3_busy_cycles", busy_n, 65);
    chk("s3_ab_order", ab_bad, 0);
    chk("s3_err", int'(err3), 0);
    chk("s3_pass", int'(pass3), 1);
    tick();

    // Start pulsed mid-sweep at idx 4 is ignored.
    run_sweep(0, 4, 1'b0, lat, busy_n, ab_bad, pulsed);
    chk("pulse_applied", pulsed, 1);
    chk("pulse_latency", lat, 33);
    chk("pulse_pass", int'(pass1), 1);
    tick();
    tick();
    chk("pulse_no_relaunch", int'(busy1), 0);

    // Start held high: back-to-back sweeps with exactly one idle cycle between.
    run_sweep(0, -1, 1'b1, lat, busy_n, ab_bad, pulsed);
    chk("held1_latency", lat, 33);
    tick();
    chk("held_gap_busy", int'(busy1), 0);
    chk("held_gap_done", int'(done1), 0);
    run_sweep(0, -1, 1'b1, lat, busy_n, ab_bad, pulsed);
    chk("held2_latency", lat, 33);
    chk("held2_pass", int'(pass1), 1);
    start1 = 1'b0;
    tick();
    tick();
    chk("held_stop_busy", int'(busy1), 0);

    // Reset while idx=7 of a faulty sweep.
    mode = 3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    guard = 0;
    while (!(a1 == 2'd1 && b1 == 2'd3) && guard < 100) begin
      tick();
      guard++;
    end
    chk("mid_reached_idx7", (guard < 100) ? 1 : 0, 1);
    chk("mid_err_before_reset", int'(err1), 6);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ab", int'({a1, b1}), 0);
    chk("mid_rst_busy", int'(busy1), 0);
    chk("mid_rst_done", int'(done1), 0);
    chk("mid_rst_pass", int'(pass1), 0);
    chk("mid_rst_err", int'(err1), 0);
    chk("mid_rst_ff", int'(ff1), 0);
    rst_n = 1'b1;
    guard = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done1 || busy1) guard++;
    end
    chk("mid_quiet_after_reset", guard, 0);
    mode = 0;
    run_sweep(0, -1, 1'b0, lat, busy_n, ab_bad, pulsed);
    chk("after_rst_latency", lat, 33);
    chk("after_rst_ab_order", ab_bad, 0);
    chk("after_rst_pass", int'(pass1), 1);
    chk("after_rst_err", int'(err1), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sumu3_exerciser.md
SUMU3_EXERCISER -- requirements
Module: sumu3_exerciser

Interface
REQ-001 Parameters SHALL be:
- SETTLE, default 1, number of cycles each vector is held before its results are sampled (legal range 1..15).
REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request to begin a full sweep
- a  output  2  operand A driven to the unit under test
- b  output  2  operand B driven to the unit under test
- sum  input  3  sum result returned by the unit under test
- mult  input  3  product result returned by the unit under test
- abb  input  3  absolute-difference result returned by the unit under test
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  high when the last sweep had zero mismatches
- err_cnt  output  5  number of failing vectors in the last sweep
- first_fail  output  4  index of the first failing vector
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-low reset (rst_n).

Function
REQ-004 The FSM SHALL have the states IDLE, SETTLE, CHECK and FINISH.
REQ-005 The vector index idx (4 bits) SHALL drive a = idx[3:2] and b = idx[1:0] in SETTLE and CHECK; in IDLE and FINISH, a and b SHALL be 0.
REQ-006 In IDLE, start=1 SHALL clear err_cnt, pass and first_fail, set idx=0, and enter SETTLE on the next edge.
REQ-007 SETTLE SHALL last exactly SETTLE cycles, counted by a 4-bit down-counter, and then enter CHECK.
REQ-008 CHECK SHALL last one cycle and compare the sampled inputs against the expected values:
- sum = a+b (3 bits)
- mult = (a*b) mod 8
- abb = |a-b|
REQ-009 Any field mismatch in CHECK SHALL increment err_cnt by exactly 1 for that vector, regardless of how many fields mismatch.
REQ-010 On the first mismatch of a sweep, first_fail SHALL capture idx; later mismatches SHALL NOT change it.
REQ-011 From CHECK, idx=15 SHALL lead to FINISH; otherwise idx SHALL increment and the FSM SHALL return to SETTLE.
REQ-012 FINISH SHALL last one cycle and assert done=1, set pass=(err_cnt==0) including any mismatch from the final CHECK, and then return to IDLE.
REQ-013 busy SHALL be 1 in SETTLE, CHECK and FINISH, and 0 in IDLE.
REQ-014 A start pulse accepted in IDLE SHALL result in done being asserted exactly 16*(SETTLE+1)+1 cycles later.
REQ-015 start SHALL be ignored while busy=1; start held high continuously SHALL launch a new sweep on the first IDLE cycle after FINISH.
REQ-016 err_cnt SHALL hold at most 16 and SHALL NOT wrap.
REQ-017 err_cnt, pass and first_fail SHALL hold their values from the end of a sweep until the next accepted start.
REQ-018 first_fail SHALL be meaningful only when err_cnt is nonzero.

Reset
REQ-019 rst_n=0 at a clock edge SHALL force the following on that edge, in any state including mid-sweep, with no done pulse:
- state = IDLE
- idx = 0, settle counter = 0
- a = 0, b = 0
- busy = 0, done = 0, pass = 0
- err_cnt = 0, first_fail = 0
REQ-020 After reset is released, the first start SHALL begin a complete sweep from idx=0.

Verification
REQ-021 Correct model, SETTLE=1, start pulse -> done 33 cycles later, err_cnt=0, pass=1, busy high for 33 cycles.
REQ-022 mult stuck at 0 -> err_cnt=9, pass=0, first_fail=5 (a=1, b=1).
REQ-023 abb stuck at 0 -> err_cnt=12, first_fail=1; sum stuck at 0 -> err_cnt=15, first_fail=1.
REQ-024 SETTLE=3, correct model -> done 65 cycles after start; a/b change every 4 cycles in the order 0/0, 0/1, ... 3/3.
REQ-025 rst_n low during idx=7 -> all outputs zero on the next edge, no done pulse; a new start then gives a full sweep with pass=1.
REQ-026 start pulsed at idx=4 during a sweep -> ignored, done timing unchanged; start held high -> back-to-back sweeps separated by exactly one IDLE cycle.
